flash_adc_conv_ctrl: RTL

Conversion controller for the 3-bit flash ADC. It strobes the comparator bank's sample/hold and waits for settling. It then synchronises and validates the 8-bit thermometer code, encodes it with bubble correction, and averages 2^AVG_LOG2 samples into one 3-bit result delivered on a valid/ready handshake. It sits between the analog comparator array and the digital consumer, taking over the sequencing that the combinational 8:3 encoder cannot do.

---
 rtl/flash_adc_conv_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/flash_adc_conv_ctrl.sv
// Conversion controller for a 3-bit flash ADC.
// Strobes the comparator sample/hold and waits for settling.
// Synchronises the thermometer code and encodes it by ones-count with bubble detection.
// Averages 2^AVG_LOG2 samples and returns one rounded result on a valid/ready handshake.
module flash_adc_conv_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned AVG_LOG2      = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_continuous,
    input  logic [7:0] i_comp_in,
    output logic       o_sample_en,
    output logic       o_busy,
    output logic [2:0] o_res_data,
    output logic       o_res_bubble,
    output logic       o_res_valid,
    input  logic       i_res_ready
);

    localparam int unsigned AccW = 3 + AVG_LOG2;
    localparam int unsigned CntW = AVG_LOG2 + 1;
    localparam int unsigned SetW = 5;

    localparam logic [CntW-1:0] NumSamples = CntW'(2 ** AVG_LOG2);
    // Half an LSB of the shifted result; zero when no averaging is done.
    localparam logic [AccW-1:0] RoundC     = AccW'((2 ** AVG_LOG2) / 2);
    // Settling plus two synchroniser stages.
    localparam logic [SetW-1:0] SettleLast = SetW'(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StSample,
        StOutput
    } state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [SetW-1:0]  r_settle_cnt;
    logic [SetW-1:0]  w_settle_cnt_nxt;
    logic [AccW-1:0]  r_acc;
    logic [AccW-1:0]  w_acc_nxt;
    logic [CntW-1:0]  r_cnt;
    logic [CntW-1:0]  w_cnt_nxt;
    logic             r_bubble;
    logic             w_bubble_nxt;
    logic [2:0]       r_res_data;
    logic [2:0]       w_res_data_nxt;
    logic             r_res_bubble;
    logic             w_res_bubble_nxt;
    logic [7:0]       r_sync1;
    logic [7:0]       r_sync2;

    logic [6:0]       w_therm;
    logic [2:0]       w_enc;
    logic             w_invalid;
    logic [AccW-1:0]  w_acc_sum;
    logic [CntW-1:0]  w_cnt_sum;
    logic [2:0]       w_rounded;

    // Two-flop synchroniser for the asynchronous comparator outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_comp_in;
            r_sync2 <= r_sync1;
        end
    end

    // Ones-count encoder; a code is legal only if bit0 is clear and bits 7:1 are 0..01..1.
    always_comb begin
        w_therm = r_sync2[7:1];
        w_enc   = '0;
        for (int i = 1; i < 8; i++) begin
            w_enc = w_enc + 3'(r_sync2[i]);
        end
        w_invalid = r_sync2[0] | ((w_therm & (w_therm + 7'd1)) != 7'd0);
        w_acc_sum = r_acc + AccW'(w_enc);
        w_cnt_sum = r_cnt + CntW'(1);
        // Maximum sum plus rounding stays below 8 after the shift, so truncation is safe.
        w_rounded = 3'((w_acc_sum + RoundC) >> AVG_LOG2);
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_settle_cnt <= '0;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_bubble     <= 1'b0;
            r_res_data   <= '0;
            r_res_bubble <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_settle_cnt <= w_settle_cnt_nxt;
            r_acc        <= w_acc_nxt;
            r_cnt        <= w_cnt_nxt;
            r_bubble     <= w_bubble_nxt;
            r_res_data   <= w_res_data_nxt;
            r_res_bubble <= w_res_bubble_nxt;
        end
    end

    // Next-state, datapath updates and Moore outputs.
    always_comb begin
        w_state_nxt      = r_state;
        w_settle_cnt_nxt = r_settle_cnt;
        w_acc_nxt        = r_acc;
        w_cnt_nxt        = r_cnt;
        w_bubble_nxt     = r_bubble;
        w_res_data_nxt   = r_res_data;
        w_res_bubble_nxt = r_res_bubble;
        o_sample_en      = 1'b0;
        o_busy           = 1'b1;
        o_res_valid      = 1'b0;

        unique case (r_state)
            StIdle: begin
                o_busy           = 1'b0;
                w_settle_cnt_nxt = '0;
                w_acc_nxt        = '0;
                w_cnt_nxt        = '0;
                w_bubble_nxt     = 1'b0;
                if (i_start || i_continuous) begin
                    w_state_nxt = StSettle;
                end
            end
            StSettle: begin
                o_sample_en = (r_settle_cnt == '0);
                if (r_settle_cnt == SettleLast) begin
                    w_settle_cnt_nxt = '0;
                    w_state_nxt      = StSample;
                end else begin
                    w_settle_cnt_nxt = r_settle_cnt + SetW'(1);
                end
            end
            StSample: begin
                w_acc_nxt    = w_acc_sum;
                w_cnt_nxt    = w_cnt_sum;
                w_bubble_nxt = r_bubble | w_invalid;
                if (w_cnt_sum == NumSamples) begin
                    w_res_data_nxt   = w_rounded;
                    w_res_bubble_nxt = r_bubble | w_invalid;
                    w_state_nxt      = StOutput;
                end else begin
                    w_state_nxt = StSettle;
                end
            end
            StOutput: begin
                o_res_valid = 1'b1;
                if (i_res_ready) begin
                    if (i_continuous) begin
                        // Back-to-back conversion: first strobe lands right after the handshake.
                        w_acc_nxt        = '0;
                        w_cnt_nxt        = '0;
                        w_bubble_nxt     = 1'b0;
                        w_settle_cnt_nxt = '0;
                        w_state_nxt      = StSettle;
                    end else begin
                        w_state_nxt = StIdle;
                    end
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    assign o_res_data   = r_res_data;
    assign o_res_bubble = r_res_bubble;

endmodule
